store_write_buffer: RTL

Post-commit store write buffer between the store data queue and the data-memory write port. It accepts committed, address-resolved stores one per cycle and holds them in a small FIFO. It drains them to memory in order over a req/ack handshake and merges repeat writes to the same word. It also answers an associative lookup so loads see store data that has committed but is not yet written.

---
 rtl/store_write_buffer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - post-commit store write buffer with coalescing, in-order drain and load forwarding
module store_write_buffer #(
    parameter int WB_ENTRIES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic              ld_vld,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              wb_empty,
    output logic              ovf_err
);
    localparam int IDX_W = $clog2(WB_ENTRIES);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;
    state_t state, state_nxt;

    logic [PTR_W-1:0]      head, tail, count;
    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic [WB_ENTRIES-1:0] ent_vld;
    logic [ADDR_W-1:0]     ent_addr [WB_ENTRIES];
    logic [DATA_W-1:0]     ent_data [WB_ENTRIES];

    logic             accept, launch, retire;
    logic             co_hit, ld_nh_hit, ld_h_hit;
    logic [IDX_W-1:0] co_idx, ld_nh_idx;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign count    = tail - head;
    assign in_ready = !rst && (count < PTR_W'(WB_ENTRIES));
    assign accept   = in_vld && in_ready;
    assign wb_empty = rst || ((count == '0) && !mem_req);

    // The head may already be in flight, so it is never a merge target; a
    // younger same-address entry is therefore unique.
    always_comb begin
        co_hit    = 1'b0;
        co_idx    = '0;
        ld_nh_hit = 1'b0;
        ld_nh_idx = '0;
        for (int i = 0; i < WB_ENTRIES; i++) begin
            if (ent_vld[i] && IDX_W'(i) != head_idx) begin
                if (ent_addr[i] == in_addr) begin
                    co_hit = 1'b1;
                    co_idx = IDX_W'(i);
                end
                if (ent_addr[i] == ld_addr) begin
                    ld_nh_hit = 1'b1;
                    ld_nh_idx = IDX_W'(i);
                end
            end
        end
    end

    assign ld_h_hit = ent_vld[head_idx] && (ent_addr[head_idx] == ld_addr);
    assign ld_hit   = !rst && ld_vld && (ld_nh_hit || ld_h_hit);
    assign ld_data  = !ld_hit   ? '0 :
                      ld_nh_hit ? ent_data[ld_nh_idx] : ent_data[head_idx];

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ent_vld[head_idx]) begin
                    launch    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            head      <= '0;
            tail      <= '0;
            ent_vld   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ovf_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                mem_req   <= 1'b1;
                mem_addr  <= ent_addr[head_idx];
                mem_wdata <= ent_data[head_idx];
            end
            if (retire) begin
                mem_req           <= 1'b0;
                ent_vld[head_idx] <= 1'b0;
                head              <= head + 1'b1;
            end
            if (accept && !co_hit) begin
                ent_vld[tail_idx] <= 1'b1;
                tail              <= tail + 1'b1;
            end
            if (in_vld && !in_ready)
                ovf_err <= 1'b1;
        end
    end

    // Entry payload carries no reset; validity alone qualifies it.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (co_hit) begin
                ent_data[co_idx] <= in_data;
            end else begin
                ent_addr[tail_idx] <= in_addr;
                ent_data[tail_idx] <= in_data;
            end
        end
    end
endmodule
